sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 20 ++
 rtl/sram_port_arbiter_if.sv | 48 ++++
 rtl/sram_port_arbiter_rr_pick.sv | 29 ++
 rtl/sram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter.
// One-hot FSM encoding and its bit indices.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package sram_port_arbiter_pkg;

  localparam int ST_W          = 2;
  localparam int ST_IDLE_BIT   = 0;
  localparam int ST_LOCKED_BIT = 1;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  localparam int DEF_ADDR_W = `ADDR_WIDTH;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and RAM-side bundle of the arbiter.
// slave = arbiter view, master = requesters plus RAM.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `ADDR_WIDTH,
  parameter int DATA_W  = 16
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             req_lock;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rvalid;
  logic [DATA_W-1:0]              rdata;
  logic                           ram_cs;
  logic                           ram_we;
  logic [ADDR_W-1:0]              ram_addr;
  logic [DATA_W-1:0]              ram_wdata;
  logic [DATA_W-1:0]              ram_rdata;
  logic                           busy;

  modport slave (
    input  req, req_lock, req_we,
    input  req_addr, req_wdata,
    input  ram_rdata,
    output gnt, rvalid, rdata,
    output ram_cs, ram_we,
    output ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output req, req_lock, req_we,
    output req_addr, req_wdata,
    output ram_rdata,
    input  gnt, rvalid, rdata,
    input  ram_cs, ram_we,
    input  ram_addr, ram_wdata,
    input  busy
  );

endinterface

// File: rtl/sram_port_arbiter_rr_pick.sv
// Rotating-priority picker: first request at or
// above i_ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int j;
    o_gnt = '0;
    o_idx = '0;
    // highest offset first so the nearest hit wins
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for one single-port buffer RAM,
// with locked bursts capped at MAX_BURST beats.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = `ADDR_WIDTH,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input logic              clk,
  input logic              rstn,
  sram_port_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      w_ptr_nxt;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      w_owner_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IW-1:0]      w_pick_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gidx;
  logic               w_acc;

  function automatic logic [IW-1:0] f_inc(
    input logic [IW-1:0] i
  );
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // a locked owner that stops requesting gets nothing;
  // nobody else may steal the slot
  always_comb begin
    w_gnt  = '0;
    w_gidx = r_owner;
    if (r_state[ST_LOCKED_BIT]) begin
      w_gnt[r_owner] = bus.req[r_owner];
    end else begin
      w_gnt  = w_pick_gnt;
      w_gidx = w_pick_idx;
    end
    if (!rstn) w_gnt = '0;
  end

  assign w_acc = |(bus.req & w_gnt);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    unique case (1'b1)
      r_state[ST_LOCKED_BIT]: begin
        if (w_acc) w_cnt_nxt = r_cnt + CW'(1);
        if (!w_acc || !bus.req_lock[r_owner]
            || r_cnt == CW'(MAX_BURST - 1)) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = f_inc(r_owner);
          w_cnt_nxt   = '0;
        end
      end
      r_state[ST_IDLE_BIT]: begin
        if (w_acc) begin
          w_ptr_nxt = f_inc(w_pick_idx);
          if (bus.req_lock[w_pick_idx] && MAX_BURST > 1) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_pick_idx;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= (w_acc && !bus.req_we[w_gidx])
                  ? w_gnt : '0;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.ram_cs    = w_acc;
  assign bus.ram_we    = w_acc & bus.req_we[w_gidx];
  assign bus.ram_addr  = w_acc ? bus.req_addr[w_gidx] : '0;
  assign bus.ram_wdata = w_acc ? bus.req_wdata[w_gidx] : '0;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = (|r_rvalid) ? bus.ram_rdata : '0;
  assign bus.busy      = r_state[ST_LOCKED_BIT]
                       | (|r_rvalid) | w_acc;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios
// and random traffic against a behavioural model.
module tb_sram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) bus ();

  sram_port_arbiter #(
    .NUM_REQ   (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ref_mem [256];

  // RAM with one cycle read latency
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) ram_mem[bus.ram_addr[7:0]] = bus.ram_wdata;
      else bus.ram_rdata <= ram_mem[bus.ram_addr[7:0]];
    end
  end

  int errors = 0;
  int checks = 0;

  bit          m_locked;
  int          m_ptr;
  int          m_owner;
  int          m_beats;
  logic [N-1:0] m_rv;
  logic [DW-1:0] m_rd;
  logic [N-1:0] e_gnt;
  int          e_idx;

  logic [N-1:0]  last_gnt;
  logic          last_cs;
  logic [N-1:0]  last_rvalid;
  logic [DW-1:0] last_rdata;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_grant();
    e_gnt = '0;
    e_idx = 0;
    if (rstn) begin
      if (m_locked) begin
        if (bus.req[m_owner]) begin
          e_gnt[m_owner] = 1'b1;
          e_idx = m_owner;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (bus.req[j] && e_gnt == '0) begin
            e_gnt[j] = 1'b1;
            e_idx = j;
          end
        end
      end
    end
  endtask

  task automatic model_update(input logic cs);
    logic [7:0] a;
    a = bus.req_addr[e_idx][7:0];
    if (!rstn) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      m_beats  = 0;
      m_rv     = '0;
    end else begin
      if (cs && !bus.req_we[e_idx]) begin
        m_rv = e_gnt;
        m_rd = ref_mem[a];
      end else begin
        m_rv = '0;
      end
      if (cs && bus.req_we[e_idx]) ref_mem[a] = bus.req_wdata[e_idx];
      if (m_locked) begin
        if (cs) m_beats++;
        if (!bus.req[m_owner] || !bus.req_lock[m_owner]
            || m_beats == MB) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
        end
      end else if (cs) begin
        m_ptr = (e_idx + 1) % N;
        if (bus.req_lock[e_idx]) begin
          m_locked = 1'b1;
          m_owner  = e_idx;
          m_beats  = 1;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    logic cs;
    model_grant();
    cs = |e_gnt;
    #1;
    last_gnt    = bus.gnt;
    last_cs     = bus.ram_cs;
    last_rvalid = bus.rvalid;
    last_rdata  = bus.rdata;
    chk({tag, ":gnt"}, 64'(bus.gnt), 64'(e_gnt));
    chk({tag, ":cs"}, 64'(bus.ram_cs), 64'(cs));
    chk({tag, ":we"}, 64'(bus.ram_we),
        64'(cs & bus.req_we[e_idx]));
    chk({tag, ":addr"}, 64'(bus.ram_addr),
        cs ? 64'(bus.req_addr[e_idx]) : 64'd0);
    chk({tag, ":wdata"}, 64'(bus.ram_wdata),
        cs ? 64'(bus.req_wdata[e_idx]) : 64'd0);
    chk({tag, ":rvalid"}, 64'(bus.rvalid), 64'(m_rv));
    chk({tag, ":busy"}, 64'(bus.busy),
        64'(m_locked || m_rv != '0 || cs));
    if (m_rv != '0) chk({tag, ":rdata"}, 64'(bus.rdata), 64'(m_rd));
    @(posedge clk);
    model_update(cs);
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] r,
                       input logic [N-1:0] l,
                       input logic [N-1:0] w);
    bus.req      = r;
    bus.req_lock = l & r;
    bus.req_we   = w;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive('0, '0, '0);
    step("rst");
    step("rst");
    rstn = 1'b1;
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rstn = 1'b0;
    drive('0, '0, '0);
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i]  = AW'(i * 16 + 3);
      bus.req_wdata[i] = DW'($urandom);
    end
    for (int a = 0; a < 256; a++) begin
      ram_mem[a] = DW'($urandom);
      ref_mem[a] = ram_mem[a];
    end
    @(negedge clk);

    // reset with all requesters asking
    drive(4'b1111, '0, '0);
    step("rst_a");
    chk("rst_gnt", 64'(last_gnt), 64'd0);
    chk("rst_cs", 64'(last_cs), 64'd0);
    step("rst_b");
    chk("rst_rvalid", 64'(last_rvalid), 64'd0);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("rr");
      chk("rr_seq", 64'(last_gnt), 64'(rr_exp[k]));
    end

    // read latency
    do_reset();
    bus.req_addr[0] = 16'h0010;
    ram_mem[16] = 16'hBEEF;
    ref_mem[16] = 16'hBEEF;
    drive(4'b0001, '0, '0);
    step("rd");
    chk("rd_gnt", 64'(last_gnt), 64'h1);
    chk("rd_rv0", 64'(last_rvalid), 64'd0);
    drive('0, '0, '0);
    step("rd1");
    chk("rd_rv1", 64'(last_rvalid), 64'h1);
    chk("rd_data", 64'(last_rdata), 64'hBEEF);
    step("rd2");
    chk("rd_rv2", 64'(last_rvalid), 64'd0);

    // burst cap on requester 2
    do_reset();
    drive(4'b0010, '0, '0);
    step("cap_pre");
    drive(4'b1111, 4'b0100, '0);
    for (int k = 0; k < MB + 1; k++) begin
      step("cap");
      chk("cap_seq", 64'(last_gnt),
          (k < MB) ? 64'h4 : 64'h8);
    end

    // lock dropped by requester 1
    do_reset();
    drive(4'b0001, '0, 4'b0001);
    step("ld_pre");
    drive(4'b0110, 4'b0010, '0);
    for (int k = 0; k < 3; k++) begin
      step("ld");
      chk("ld_lock", 64'(last_gnt), 64'h2);
    end
    drive(4'b0110, '0, '0);
    step("ld_drop");
    chk("ld_drop", 64'(last_gnt), 64'h2);
    step("ld_next");
    chk("ld_next", 64'(last_gnt), 64'h4);

    // reset on 4th beat of a read burst
    do_reset();
    drive(4'b0001, 4'b0001, '0);
    for (int k = 0; k < 3; k++) step("mb");
    rstn = 1'b0;
    step("mb_rst");
    chk("mb_gnt", 64'(last_gnt), 64'd0);
    chk("mb_cs", 64'(last_cs), 64'd0);
    rstn = 1'b1;
    drive(4'b1111, '0, '0);
    step("mb_post");
    chk("mb_rvalid", 64'(last_rvalid), 64'd0);
    chk("mb_gnt0", 64'(last_gnt), 64'h1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      rstn = ($urandom_range(0, 49) != 0);
      r = N'($urandom);
      l = ($urandom_range(0, 2) != 0) ? N'($urandom) : '0;
      drive(r, l, N'($urandom));
      for (int i = 0; i < N; i++) begin
        bus.req_addr[i]  = AW'($urandom_range(0, 255));
        bus.req_wdata[i] = DW'($urandom);
      end
      step("rand");
    end
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
